mux21_arbiter: RTL and testbench
================================

Name: mux21_arbiter

Overview:
- 2:1 merge block: drains two upstream FIFOs (source 0, source 1) onto one downstream stream; counterpart of the 1:2 classifying demux.
- Generates pops toward the source FIFOs and pushes toward the downstream FIFO.
- Arbitrates with burst-limited round-robin and stalls on downstream almost-full.
- Sits between the per-class FIFO stage and the downstream FIFO on the merge path.

Parameters:
- DATA_SIZE, 10, width of each data word.
- BURST_MAX, 4, maximum consecutive pops from one source while the other is non-empty (legal range 1..15).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in0  input  DATA_SIZE  read data from source FIFO 0; valid the cycle after pop_0.
- in1  input  DATA_SIZE  read data from source FIFO 1; valid the cycle after pop_1.
- fifo0_empty  input  1  source FIFO 0 empty.
- fifo1_empty  input  1  source FIFO 1 empty.
- fifo_out_almostfull  input  1  downstream FIFO almost full.
- pop_0  output  1  combinational read strobe to source FIFO 0.
- pop_1  output  1  combinational read strobe to source FIFO 1.
- out  output  DATA_SIZE  registered merged data.
- push  output  1  registered write strobe to the downstream FIFO.

Behaviour:
- Reset (async, active-high): push=0; out=0; grant g=0; burst count bc=0; in-flight flag vld_d=0; sel_d=0.
- pop_0 and pop_1 are forced to 0 while reset is high.
- Reset mid-operation: any word already popped but not yet pushed is discarded; no push follows the reset.
- Per-cycle selection (combinational):
  - o = ~g.
  - sel = o if (fifoG_empty && !fifoO_empty) || (bc==BURST_MAX && !fifoO_empty); otherwise sel = g.
- Pop generation: pop_sel = !fifo_out_almostfull && !fifo{sel}_empty && !reset; the other pop is 0.
  - At most one pop per cycle.
  - Never pop an empty FIFO.
- On an edge where a pop occurred:
  - g <= sel.
  - bc <= (sel==g) ? min(bc+1, BURST_MAX) : 1.
  - vld_d <= 1; sel_d <= sel.
- On an edge without a pop: g and bc hold; vld_d <= 0.
- Capture:
  - If vld_d: out <= sel_d ? in1 : in0; push <= 1.
  - Otherwise: push <= 0; out holds its last value.
- Latency: pop in cycle N → source data valid in N+1 → out/push valid in N+2.
- Throughput: one word per cycle sustained.
- Almost-full:
  - Stops new pops in the same cycle it is seen.
  - Up to 2 in-flight words still push.
  - Downstream almost-full threshold must allow at least 2 entries of slack.
- Both sources empty: no pops; g and bc hold.
- BURST_MAX=1 with both sources non-empty: strict alternation 0,1,0,1...
- A single non-empty source is drained back-to-back regardless of BURST_MAX.

Optional Feature:
- Macro: MUX21_ARBITER_COUNT_EN.
- Defined: adds outputs cnt0 and cnt1 (16-bit each).
  - Each counts pushes originating from source 0 / source 1 respectively.
  - Each increments on the edge where push is set for that source.
  - Wraps 0xFFFF→0x0000; reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package mux21_pkg:
  - SRC0=1'b0, SRC1=1'b1 encodings.
  - BURST_W=4 (bc width).
  - CNT_W=16.
- Sub-module mux21_rr_arbiter:
  - Contains g, bc and the sel/pop logic.
  - Inputs: empties, almostfull, reset.
  - Outputs: pop_0, pop_1, sel.
- Top module holds the capture pipeline (vld_d, sel_d, out, push) and the optional counters.

Test Plan:
- Reset release:
  - Stimulus: assert reset mid-cycle with both FIFOs non-empty.
  - Required: pops 0 immediately; push=0, out=0 while reset is high; first pop_0 on the first cycle after reset drops.
- Single source:
  - Stimulus: fifo0 holds 0x001..0x005; fifo1 empty.
  - Required: pop_0 asserted 5 consecutive cycles; push asserted 5 cycles starting 2 cycles later; out=0x001..0x005 in order.
- Burst limit:
  - Stimulus: BURST_MAX=4; fifo0 holds 8 words (0x010+), fifo1 holds 8 words (0x020+).
  - Required output order: 0x010-0x013, 0x020-0x023, 0x014-0x017, 0x024-0x027.
- Almost-full stall:
  - Stimulus: raise fifo_out_almostfull for 3 cycles during streaming.
  - Required: pops stop in the same cycle; exactly 2 further pushes; pops and pushes resume 1 and 3 cycles after it drops; no word lost or duplicated.
- Empty boundary:
  - Stimulus: fifo1 goes empty the cycle after its last pop while fifo0 is non-empty.
  - Required: no pop_1 while empty; selection switches to source 0 without a bubble.
- Counter option:
  - Stimulus: MUX21_ARBITER_COUNT_EN defined; preload cnt0=0xFFFE by 65534 pushes, then 3 more source-0 words.
  - Required: cnt0 = 0xFFFF, 0x0000, 0x0001; cnt1 unchanged.

Source files
------------

// File: rtl/mux21_pkg.sv
// Shared source encodings, widths and the burst-count helper for the 2:1 merge arbiter.
package mux21_pkg;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_e;

    localparam int BURST_W = 4;
    localparam int CNT_W   = 16;

    // Run length of the current grant, saturating at the burst limit.
    function automatic logic [BURST_W-1:0] burst_next(input logic [BURST_W-1:0] bc,
                                                      input logic [BURST_W-1:0] lim);
        return (bc >= lim) ? lim : bc + 1'b1;
    endfunction

endpackage

// File: rtl/mux21_arbiter_if.sv
// Bus bundle between the two source FIFOs, the merge arbiter and the downstream FIFO.
// slave is the arbiter's view; master is the view of whatever drives the FIFOs around it.
interface mux21_arbiter_if #(
    parameter int DATA_SIZE = 10
);
    logic [DATA_SIZE-1:0] in0;
    logic [DATA_SIZE-1:0] in1;
    logic                 fifo0_empty;
    logic                 fifo1_empty;
    logic                 fifo_out_almostfull;
    logic                 pop_0;
    logic                 pop_1;
    logic [DATA_SIZE-1:0] out;
    logic                 push;

    modport slave (
        input  in0, in1, fifo0_empty, fifo1_empty, fifo_out_almostfull,
        output pop_0, pop_1, out, push
    );

    modport master (
        output in0, in1, fifo0_empty, fifo1_empty, fifo_out_almostfull,
        input  pop_0, pop_1, out, push
    );
endinterface

// File: rtl/mux21_rr_arbiter.sv
// Burst-limited round-robin grant between the two source FIFOs; pops are combinational
// and the grant/run-length state only advances on cycles that actually pop.
module mux21_rr_arbiter
    import mux21_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic fifo0_empty,
    input  logic fifo1_empty,
    input  logic fifo_out_almostfull,
    output logic pop_0,
    output logic pop_1,
    output src_e sel
);

    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);

    src_e               g;
    src_e               o;
    logic [BURST_W-1:0] bc;
    logic               g_empty;
    logic               o_empty;
    logic               sel_empty;
    logic               pop;

    // Stay on the granted source unless it ran dry or used its burst while the other waits.
    always_comb begin
        o         = (g == SRC0) ? SRC1 : SRC0;
        g_empty   = (g == SRC1) ? fifo1_empty : fifo0_empty;
        o_empty   = (o == SRC1) ? fifo1_empty : fifo0_empty;
        sel       = g;
        if (!o_empty && (g_empty || bc == BURST_LIM)) begin
            sel = o;
        end
        sel_empty = (sel == SRC1) ? fifo1_empty : fifo0_empty;
        pop       = !fifo_out_almostfull && !sel_empty && !reset;
        pop_0     = pop && (sel == SRC0);
        pop_1     = pop && (sel == SRC1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g  <= SRC0;
            bc <= '0;
        end else if (pop) begin
            g  <= sel;
            bc <= (sel == g) ? burst_next(bc, BURST_LIM) : BURST_W'(1);
        end
    end

endmodule

// File: rtl/mux21_arbiter.sv
// 2:1 merge: arbitrates two source FIFOs onto one downstream FIFO with a two-stage capture.
// Optional feature macro MUX21_ARBITER_COUNT_EN adds per-source push counters cnt0/cnt1.
module mux21_arbiter
    import mux21_pkg::*;
#(
    parameter int DATA_SIZE = 10,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    mux21_arbiter_if.slave    bus
`ifdef MUX21_ARBITER_COUNT_EN
    ,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
`endif
);

    src_e                 sel;
    src_e                 sel_d;
    logic                 vld_d;
    logic [DATA_SIZE-1:0] capt;

    mux21_rr_arbiter #(
        .BURST_MAX(BURST_MAX)
    ) u_arb (
        .clk                (clk),
        .reset              (reset),
        .fifo0_empty        (bus.fifo0_empty),
        .fifo1_empty        (bus.fifo1_empty),
        .fifo_out_almostfull(bus.fifo_out_almostfull),
        .pop_0              (bus.pop_0),
        .pop_1              (bus.pop_1),
        .sel                (sel)
    );

    always_comb begin
        capt = (sel_d == SRC1) ? bus.in1 : bus.in0;
    end

    // Source data shows up the cycle after the pop, so the push lands two cycles after it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_d    <= 1'b0;
            sel_d    <= SRC0;
            bus.out  <= '0;
            bus.push <= 1'b0;
        end else begin
            vld_d    <= bus.pop_0 | bus.pop_1;
            if (bus.pop_0 | bus.pop_1) begin
                sel_d <= sel;
            end
            bus.push <= vld_d;
            if (vld_d) begin
                bus.out <= capt;
            end
        end
    end

`ifdef MUX21_ARBITER_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (vld_d) begin
            if (sel_d == SRC1) begin
                cnt1 <= cnt1 + 1'b1;
            end else begin
                cnt0 <= cnt0 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux21_arbiter.sv
// Bench for mux21_arbiter: source FIFOs modelled as queues, arbitration predicted from the
// round-robin rules over the grant history. Also checks cnt0/cnt1 when MUX21_ARBITER_COUNT_EN is set.
module tb_mux21_arbiter;
    import mux21_pkg::*;

    localparam int DW   = 10;
    localparam int BMAX = 4;

    typedef logic [DW-1:0] word_t;

    typedef struct {
        bit e0;
        bit e1;
        bit af;
        bit p0;
        bit p1;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mux21_arbiter_if #(.DATA_SIZE(DW)) bus ();

`ifdef MUX21_ARBITER_COUNT_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] mcnt [2];
`endif

    mux21_arbiter #(
        .DATA_SIZE(DW),
        .BURST_MAX(BMAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef MUX21_ARBITER_COUNT_EN
        ,
        .cnt0 (cnt0),
        .cnt1 (cnt1)
`endif
    );

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    word_t q0[$];
    word_t q1[$];
    int    hist[$];
    bit    prev_vld;
    word_t prev_word;
    int    prev_src;
    word_t last_out;
    word_t outs[$];
    int    pop_cyc[$];
    int    push_cyc[$];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Which source must pop this cycle (-1 = none), from the arbitration rules and the grant history.
    function automatic int exp_src();
        int last;
        int run;
        if (reset || bus.fifo_out_almostfull) return -1;
        if (q0.size() == 0 && q1.size() == 0) return -1;
        if (q1.size() == 0) return 0;
        if (q0.size() == 0) return 1;
        if (hist.size() == 0) return 0;
        last = hist[hist.size()-1];
        run  = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == last; i--) run++;
        return (run >= BMAX) ? 1 - last : last;
    endfunction

    // One clock: check pops before the edge, move the FIFO model, check the registered outputs after it.
    task automatic tick();
        int    es;
        word_t w = '0;
        bus.fifo0_empty = (q0.size() == 0);
        bus.fifo1_empty = (q1.size() == 0);
        #2;
        es = exp_src();
        check_output("pop_0", {31'b0, bus.pop_0}, {31'b0, es == 0});
        check_output("pop_1", {31'b0, bus.pop_1}, {31'b0, es == 1});
        if (es >= 0) begin
            w = (es == 1) ? q1.pop_front() : q0.pop_front();
            hist.push_back(es);
            if (hist.size() > 2 * BMAX) void'(hist.pop_front());
            pop_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (es == 0) bus.in0 = w;
        else if (es == 1) bus.in1 = w;
        if (prev_vld) begin
            last_out = prev_word;
`ifdef MUX21_ARBITER_COUNT_EN
            mcnt[prev_src] = mcnt[prev_src] + 1'b1;
`endif
        end
        check_output("push", {31'b0, bus.push}, {31'b0, prev_vld});
        check_output("out", 32'(bus.out), 32'(last_out));
        if (bus.push) begin
            outs.push_back(bus.out);
            push_cyc.push_back(cyc);
        end
`ifdef MUX21_ARBITER_COUNT_EN
        check_output("cnt0", 32'(cnt0), 32'(mcnt[0]));
        check_output("cnt1", 32'(cnt1), 32'(mcnt[1]));
`endif
        prev_vld  = (es >= 0);
        prev_word = w;
        prev_src  = (es >= 0) ? es : 0;
    endtask

    // Called one time unit after an edge: raises reset in the middle of the cycle.
    task automatic assert_reset_mid();
        #3;
        reset = 1'b1;
        #1;
        prev_vld = 1'b0;
        last_out = '0;
        hist.delete();
`ifdef MUX21_ARBITER_COUNT_EN
        mcnt[0] = '0;
        mcnt[1] = '0;
`endif
        check_output("rst_pop_0", {31'b0, bus.pop_0}, 32'd0);
        check_output("rst_pop_1", {31'b0, bus.pop_1}, 32'd0);
        check_output("rst_push", {31'b0, bus.push}, 32'd0);
        check_output("rst_out", 32'(bus.out), 32'd0);
    endtask

    task automatic new_test();
        q0.delete();
        q1.delete();
        bus.fifo_out_almostfull = 1'b0;
        assert_reset_mid();
        tick();
        #3;
        reset = 1'b0;
        outs.delete();
        pop_cyc.delete();
        push_cyc.delete();
    endtask

    task automatic load(input int src, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            if (src == 1) q1.push_back(word_t'(base + i));
            else q0.push_back(word_t'(base + i));
        end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        bus.fifo_out_almostfull = 1'b0;
        while ((q0.size() != 0 || q1.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) check_output("drain_budget", 32'd1, 32'd0);
        tick();
        tick();
    endtask

    vec_t vecs[8];

    initial begin
        int a;
        int cnt_ok;
        int exp_w;
        int seen[int];
        word_t cntlog[$];

        bus.in0 = '0;
        bus.in1 = '0;
        bus.fifo0_empty = 1'b1;
        bus.fifo1_empty = 1'b1;
        bus.fifo_out_almostfull = 1'b0;
        prev_vld  = 1'b0;
        prev_word = '0;
        prev_src  = 0;
        last_out  = '0;
`ifdef MUX21_ARBITER_COUNT_EN
        mcnt[0] = '0;
        mcnt[1] = '0;
`endif

        // Freshly reset grant (g=0, bc=0): pops depend only on empties and almost-full.
        vecs[0] = '{e0:0, e1:0, af:0, p0:1, p1:0};
        vecs[1] = '{e0:0, e1:0, af:1, p0:0, p1:0};
        vecs[2] = '{e0:0, e1:1, af:0, p0:1, p1:0};
        vecs[3] = '{e0:0, e1:1, af:1, p0:0, p1:0};
        vecs[4] = '{e0:1, e1:0, af:0, p0:0, p1:1};
        vecs[5] = '{e0:1, e1:0, af:1, p0:0, p1:0};
        vecs[6] = '{e0:1, e1:1, af:0, p0:0, p1:0};
        vecs[7] = '{e0:1, e1:1, af:1, p0:0, p1:0};

        @(posedge clk);
        #1;
        check_output("reset_push", {31'b0, bus.push}, 32'd0);
        check_output("reset_out", 32'(bus.out), 32'd0);
        bus.fifo0_empty = 1'b0;
        #1;
        check_output("reset_pop_0", {31'b0, bus.pop_0}, 32'd0);
        bus.fifo0_empty = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            bus.fifo0_empty = vecs[i].e0;
            bus.fifo1_empty = vecs[i].e1;
            bus.fifo_out_almostfull = vecs[i].af;
            #2;
            check_output($sformatf("vec%0d_pop_0", i), {31'b0, bus.pop_0}, {31'b0, vecs[i].p0});
            check_output($sformatf("vec%0d_pop_1", i), {31'b0, bus.pop_1}, {31'b0, vecs[i].p1});
            check_output($sformatf("vec%0d_push", i), {31'b0, bus.push}, 32'd0);
            bus.fifo0_empty = 1'b1;
            bus.fifo1_empty = 1'b1;
            bus.fifo_out_almostfull = 1'b0;
            @(posedge clk);
            #1;
        end

        // Reset in the middle of streaming drops the in-flight word and restarts on source 0.
        load(0, 'h100, 6);
        load(1, 'h180, 6);
        tick();
        tick();
        tick();
        assert_reset_mid();
        tick();
        tick();
        #3;
        reset = 1'b0;
        pop_cyc.delete();
        tick();
        check_output("first_pop_after_reset", 32'(pop_cyc.size()), 32'd1);
        drain(40);

        // Single source drained back to back.
        new_test();
        load(0, 'h001, 5);
        drain(20);
        check_output("single_count", 32'(outs.size()), 32'd5);
        for (int i = 0; i < outs.size() && i < 5; i++) begin
            check_output("single_word", 32'(outs[i]), 32'(i + 1));
            check_output("single_pop_cyc", 32'(pop_cyc[i]), 32'(pop_cyc[0] + i));
            check_output("single_push_cyc", 32'(push_cyc[i]), 32'(pop_cyc[0] + 2 + i));
        end

        // Burst limit of 4 with both sources full.
        new_test();
        load(0, 'h010, 8);
        load(1, 'h020, 8);
        drain(40);
        check_output("burst_count", 32'(outs.size()), 32'd16);
        for (int i = 0; i < outs.size() && i < 16; i++) begin
            exp_w = (((i / 4) % 2 == 1) ? 'h020 : 'h010) + (i / 8) * 4 + (i % 4);
            check_output("burst_order", 32'(outs[i]), 32'(exp_w));
        end

        // Almost-full held for three cycles in the middle of streaming.
        new_test();
        load(0, 'h040, 10);
        load(1, 'h060, 10);
        repeat (4) tick();
        a = cyc;
        bus.fifo_out_almostfull = 1'b1;
        repeat (3) tick();
        bus.fifo_out_almostfull = 1'b0;
        drain(60);
        cnt_ok = 0;
        foreach (push_cyc[i]) if (push_cyc[i] >= a && push_cyc[i] <= a + 2) cnt_ok++;
        check_output("af_pushes_after", 32'(cnt_ok), 32'd2);
        exp_w = -1;
        foreach (pop_cyc[i]) if (exp_w < 0 && pop_cyc[i] >= a) exp_w = pop_cyc[i];
        check_output("af_pop_resume", 32'(exp_w), 32'(a + 3));
        exp_w = -1;
        foreach (push_cyc[i]) if (exp_w < 0 && push_cyc[i] > a + 1) exp_w = push_cyc[i];
        check_output("af_push_resume", 32'(exp_w), 32'(a + 5));
        foreach (outs[i]) seen[int'(outs[i])] = seen.exists(int'(outs[i])) ? seen[int'(outs[i])] + 1 : 1;
        cnt_ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (seen.exists('h040 + i) && seen['h040 + i] == 1) cnt_ok++;
            if (seen.exists('h060 + i) && seen['h060 + i] == 1) cnt_ok++;
        end
        check_output("af_words_once", 32'(cnt_ok), 32'd20);
        check_output("af_word_count", 32'(outs.size()), 32'd20);

        // Source 1 runs dry right after its last pop; source 0 continues with no bubble.
        new_test();
        load(0, 'h200, 6);
        load(1, 'h300, 2);
        drain(30);
        check_output("empty_count", 32'(outs.size()), 32'd8);
        check_output("empty_contiguous", 32'(pop_cyc[pop_cyc.size()-1] - pop_cyc[0]), 32'd7);
        for (int i = 0; i < outs.size() && i < 8; i++) begin
            exp_w = (i < 4) ? 'h200 + i : (i < 6) ? 'h300 + (i - 4) : 'h200 + (i - 2);
            check_output("empty_order", 32'(outs[i]), 32'(exp_w));
        end

        // Random fill and almost-full against the rule model.
        new_test();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(2) == 0 && q0.size() < 12) q0.push_back(word_t'($urandom));
            if ($urandom_range(2) == 0 && q1.size() < 12) q1.push_back(word_t'($urandom));
            bus.fifo_out_almostfull = ($urandom_range(4) == 0);
            tick();
        end
        drain(100);

`ifdef MUX21_ARBITER_COUNT_EN
        // Counter wrap: 65534 source-0 pushes, then three more.
        new_test();
        load(0, 0, 65534);
        drain(66000);
        check_output("cnt0_preload", 32'(cnt0), 32'hFFFE);
        load(0, 'h3A0, 3);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.push) cntlog.push_back(word_t'(0));
            if (bus.push) cntlog[cntlog.size()-1] = word_t'(cnt0 & 16'h3FF);
            if (bus.push && i < 5) check_output("cnt0_wrap_step", 32'(cnt0),
                32'((32'hFFFF + cntlog.size() - 1) & 32'hFFFF));
        end
        check_output("cnt0_wrap_pushes", 32'(cntlog.size()), 32'd3);
        check_output("cnt0_final", 32'(cnt0), 32'h0001);
        check_output("cnt1_unchanged", 32'(cnt1), 32'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
